majority_window_sched: RTL and testbench

- Round-robin scheduler that shares one 3-bit-window majority detector among NUM_CH serial bit requesters.
- Each channel keeps its own 3-bit history context; one granted channel is serviced per cycle.
- The shared detector computes the 2-of-3 majority of the updated history for the serviced channel.
- Sits between per-lane serial front-ends and downstream event logic that consumes the tagged majority results.

---
 rtl/majority_window_sched_if.sv | 46 ++++
 rtl/majority_window_sched.sv | 123 ++++++++++++
 tb/tb_majority_window_sched.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/majority_window_sched_if.sv
// Request/grant and tagged-result bundle for majority_window_sched.
// out_rise is present only when MAJ_EDGE_DET_EN is defined.
interface majority_window_sched_if #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = $clog2(NUM_CH)
);
  logic [NUM_CH-1:0] req;
  logic [NUM_CH-1:0] bit_in;
  logic [NUM_CH-1:0] clr_ch;
  logic [NUM_CH-1:0] grant;
  logic              out_valid;
  logic [CH_W-1:0]   out_ch;
  logic              out_bit;
  logic [2:0]        out_hist;
`ifdef MAJ_EDGE_DET_EN
  logic              out_rise;
`endif

  modport master (
    output req,
    output bit_in,
    output clr_ch,
    input  grant,
    input  out_valid,
    input  out_ch,
    input  out_bit,
`ifdef MAJ_EDGE_DET_EN
    input  out_rise,
`endif
    input  out_hist
  );

  modport slave (
    input  req,
    input  bit_in,
    input  clr_ch,
    output grant,
    output out_valid,
    output out_ch,
    output out_bit,
`ifdef MAJ_EDGE_DET_EN
    output out_rise,
`endif
    output out_hist
  );
endinterface

// File: rtl/majority_window_sched.sv
// Round-robin sharing of one 3-bit majority detector across NUM_CH serial lanes.
// Optional rising-edge output out_rise when MAJ_EDGE_DET_EN is defined.
module majority_window_sched #(
  parameter  int NUM_CH = 4,
  localparam int CH_W   = $clog2(NUM_CH)
) (
  input  logic clk,
  input  logic rst,
  majority_window_sched_if.slave bus
);

  logic [CH_W-1:0]   r_last;
  logic [2:0]        r_hist [NUM_CH];
  logic              r_valid;
  logic [CH_W-1:0]   r_ch;
  logic              r_bit;
  logic [2:0]        r_hist_o;

  logic [NUM_CH-1:0] w_grant;
  logic              w_found;
  logic [CH_W-1:0]   w_gidx;
  logic [CH_W-1:0]   w_j;
  logic [1:0]        w_keep;
  logic [2:0]        w_new_hist;
  logic              w_new_maj;

  // First requester strictly after the last serviced channel, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_gidx  = '0;
    w_grant = '0;
    w_j     = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      w_j = CH_W'((int'(r_last) + k) % NUM_CH);
      if (!w_found && bus.req[w_j]) begin
        w_found = 1'b1;
        w_gidx  = w_j;
      end
    end
    if (rst) begin
      w_found = 1'b0;
    end
    if (w_found) begin
      w_grant[w_gidx] = 1'b1;
    end
  end

  // A same-cycle clear wipes the old bits before the new one shifts in.
  always_comb begin
    w_keep     = bus.clr_ch[w_gidx] ? 2'b00 : r_hist[w_gidx][1:0];
    w_new_hist = {w_keep, bus.bit_in[w_gidx]};
    w_new_maj  = (w_new_hist[0] & w_new_hist[1]) |
                 (w_new_hist[1] & w_new_hist[2]) |
                 (w_new_hist[2] & w_new_hist[0]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_hist[i] <= 3'b000;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_found && (w_gidx == CH_W'(i))) begin
          r_hist[i] <= w_new_hist;
        end else if (bus.clr_ch[i]) begin
          r_hist[i] <= 3'b000;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last   <= CH_W'(NUM_CH - 1);
      r_valid  <= 1'b0;
      r_ch     <= '0;
      r_bit    <= 1'b0;
      r_hist_o <= 3'b000;
    end else if (w_found) begin
      r_last   <= w_gidx;
      r_valid  <= 1'b1;
      r_ch     <= w_gidx;
      r_bit    <= w_new_maj;
      r_hist_o <= w_new_hist;
    end else begin
      r_valid  <= 1'b0;
    end
  end

`ifdef MAJ_EDGE_DET_EN
  logic [NUM_CH-1:0] r_prev_maj;
  logic              r_rise;
  logic              w_prev_eff;

  assign w_prev_eff = r_prev_maj[w_gidx] & ~bus.clr_ch[w_gidx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev_maj <= '0;
      r_rise     <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_found && (w_gidx == CH_W'(i))) begin
          r_prev_maj[i] <= w_new_maj;
        end else if (bus.clr_ch[i]) begin
          r_prev_maj[i] <= 1'b0;
        end
      end
      r_rise <= w_found & w_new_maj & ~w_prev_eff;
    end
  end

  assign bus.out_rise = r_rise;
`endif

  assign bus.grant     = w_grant;
  assign bus.out_valid = r_valid;
  assign bus.out_ch    = r_ch;
  assign bus.out_bit   = r_bit;
  assign bus.out_hist  = r_hist_o;

endmodule

// File: tb/tb_majority_window_sched.sv
// Directed table plus randomized run of majority_window_sched against a
// queue-free arithmetic reference model.
module tb_majority_window_sched;

  localparam int N = 4;

  logic clk;
  logic rst;

  majority_window_sched_if #(.NUM_CH(N)) ifc ();

  majority_window_sched #(.NUM_CH(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic [3:0] bv;
    logic [3:0] clr;
    logic [3:0] g;
    logic       v;
    int         ch;
    logic       ob;
    logic [2:0] h;
    logic       rise;
  } vec_t;

  vec_t tab[$];

  int n_vec;
  int n_bad;

  int m_hist [N];
  int m_prev [N];
  int m_last;
  logic [3:0] m_g;
  logic m_v;
  int   m_ch;
  logic m_bit;
  int   m_ho;
  logic m_rise;

  logic [3:0] a_grant;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_hist[i] = 0;
      m_prev[i] = 0;
    end
    m_last = N - 1;
    m_v = 0; m_ch = 0; m_bit = 0; m_ho = 0; m_rise = 0;
  endtask

  task automatic model_step(input logic [3:0] r, input logic [3:0] b,
                            input logic [3:0] c);
    int g;
    int mj;
    g = -1;
    for (int k = 1; k <= N; k++) begin
      if (g < 0 && r[(m_last + k) % N]) g = (m_last + k) % N;
    end
    m_g = (g < 0) ? 4'd0 : 4'(1 << g);
    for (int i = 0; i < N; i++) begin
      if (c[i]) begin
        m_hist[i] = 0;
        m_prev[i] = 0;
      end
    end
    if (g >= 0) begin
      m_hist[g] = (m_hist[g] * 2 + int'(b[g])) % 8;
      mj = ($countones(m_hist[g]) >= 2) ? 1 : 0;
      m_rise = (mj == 1) && (m_prev[g] == 0);
      m_prev[g] = mj;
      m_last = g;
      m_v = 1; m_ch = g; m_bit = mj[0]; m_ho = m_hist[g];
    end else begin
      m_v = 0;
      m_rise = 0;
    end
  endtask

  task automatic apply(input logic [3:0] r, input logic [3:0] b,
                       input logic [3:0] c);
    ifc.req = r; ifc.bit_in = b; ifc.clr_ch = c;
    #1;
    a_grant = ifc.grant;
    model_step(r, b, c);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, " grant"}, int'(a_grant), int'(m_g));
    chk({tag, " valid"}, int'(ifc.out_valid), int'(m_v));
    chk({tag, " ch"},    int'(ifc.out_ch), m_ch);
    chk({tag, " bit"},   int'(ifc.out_bit), int'(m_bit));
    chk({tag, " hist"},  int'(ifc.out_hist), m_ho);
`ifdef MAJ_EDGE_DET_EN
    chk({tag, " rise"},  int'(ifc.out_rise), int'(m_rise));
`endif
  endtask

  task automatic add(input logic [3:0] r, input logic [3:0] b,
                     input logic [3:0] c, input logic [3:0] g,
                     input logic v, input int ch, input logic ob,
                     input logic [2:0] h, input logic rs);
    vec_t t;
    t.req = r; t.bv = b; t.clr = c; t.g = g; t.v = v;
    t.ch = ch; t.ob = ob; t.h = h; t.rise = rs;
    tab.push_back(t);
  endtask

  logic [3:0] pend;
  logic [3:0] pbit;
  logic [3:0] clr;

  initial begin
    n_vec = 0;
    n_bad = 0;
    // contention from reset
    for (int i = 0; i < 8; i++)
      add(4'hF, 4'h0, 4'h0, 4'(1 << (i % 4)), 1, i % 4, 0, 3'd0, 0);
    // single channel 2: bits 1,1,0,0
    add(4'h4, 4'h4, 4'h0, 4'h4, 1, 2, 0, 3'b001, 0);
    add(4'h4, 4'h4, 4'h0, 4'h4, 1, 2, 1, 3'b011, 1);
    add(4'h4, 4'h0, 4'h0, 4'h4, 1, 2, 1, 3'b110, 0);
    add(4'h4, 4'h0, 4'h0, 4'h4, 1, 2, 0, 3'b100, 0);
    // skip and wrap
    add(4'h2, 4'h0, 4'h0, 4'h2, 1, 1, 0, 3'b000, 0);
    add(4'h9, 4'h0, 4'h0, 4'h8, 1, 3, 0, 3'b000, 0);
    add(4'h9, 4'h0, 4'h0, 4'h1, 1, 0, 0, 3'b000, 0);
    add(4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 3'b000, 0);
    add(4'hF, 4'h0, 4'h0, 4'h2, 1, 1, 0, 3'b000, 0);
    // ch2 to 111, then clear collision
    add(4'h4, 4'h4, 4'h0, 4'h4, 1, 2, 0, 3'b001, 0);
    add(4'h4, 4'h4, 4'h0, 4'h4, 1, 2, 1, 3'b011, 1);
    add(4'h4, 4'h4, 4'h0, 4'h4, 1, 2, 1, 3'b111, 0);
    add(4'h4, 4'h4, 4'h4, 4'h4, 1, 2, 0, 3'b001, 0);
    // other channels untouched
    add(4'h1, 4'h1, 4'h0, 4'h1, 1, 0, 0, 3'b001, 0);
    add(4'h2, 4'h2, 4'h0, 4'h2, 1, 1, 0, 3'b001, 0);
    add(4'h8, 4'h8, 4'h0, 4'h8, 1, 3, 0, 3'b001, 0);
    // clear alone, outputs hold
    add(4'h0, 4'h0, 4'h1, 4'h0, 0, 3, 0, 3'b001, 0);
    // ch0 bits 1,1,1,0,0
    add(4'h1, 4'h1, 4'h0, 4'h1, 1, 0, 0, 3'b001, 0);
    add(4'h1, 4'h1, 4'h0, 4'h1, 1, 0, 1, 3'b011, 1);
    add(4'h1, 4'h1, 4'h0, 4'h1, 1, 0, 1, 3'b111, 0);
    add(4'h1, 4'h0, 4'h0, 4'h1, 1, 0, 1, 3'b110, 0);
    add(4'h1, 4'h0, 4'h0, 4'h1, 1, 0, 0, 3'b100, 0);

    // reset with all requests pending
    rst = 1'b1;
    ifc.req = 4'hF; ifc.bit_in = 4'h0; ifc.clr_ch = 4'h0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst grant", int'(ifc.grant), 0);
    chk("rst valid", int'(ifc.out_valid), 0);
    chk("rst ch",    int'(ifc.out_ch), 0);
    chk("rst bit",   int'(ifc.out_bit), 0);
    chk("rst hist",  int'(ifc.out_hist), 0);
`ifdef MAJ_EDGE_DET_EN
    chk("rst rise",  int'(ifc.out_rise), 0);
`endif
    rst = 1'b0;
    #1;
    chk("post-rst grant", int'(ifc.grant), 1);

    foreach (tab[i]) begin
      apply(tab[i].req, tab[i].bv, tab[i].clr);
      chk($sformatf("row%0d grant", i), int'(a_grant), int'(tab[i].g));
      chk($sformatf("row%0d valid", i), int'(ifc.out_valid), int'(tab[i].v));
      chk($sformatf("row%0d ch", i),    int'(ifc.out_ch), tab[i].ch);
      chk($sformatf("row%0d bit", i),   int'(ifc.out_bit), int'(tab[i].ob));
      chk($sformatf("row%0d hist", i),  int'(ifc.out_hist), int'(tab[i].h));
`ifdef MAJ_EDGE_DET_EN
      chk($sformatf("row%0d rise", i),  int'(ifc.out_rise), int'(tab[i].rise));
`endif
    end

    // randomized: requests held with their bit until granted
    pend = 4'h0;
    pbit = 4'h0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && ($urandom_range(0, 2) != 0)) begin
          pend[i] = 1'b1;
          pbit[i] = 1'($urandom_range(0, 1));
        end
      end
      clr = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      if (c == 200) begin
        rst = 1'b1;
        #1;
        model_reset();
        chk("midrst grant", int'(ifc.grant), 0);
        chk("midrst valid", int'(ifc.out_valid), 0);
        chk("midrst hist",  int'(ifc.out_hist), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
      end
      apply(pend, pbit, clr);
      chk_model($sformatf("rnd%0d", c));
      pend = pend & ~m_g;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
